// File: rtl/mips_control_fsm.sv
// Multicycle MIPS control unit: owns the sequencing state register and
// decodes the IR into PC, IR, Avalon memory, register-file and HI/LO
// control. Handles sub-word byte enables, misalignment trapping,
// branch-delay-slot redirection and a fixed-latency multiply/divide wait.
module mips_control_fsm #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter bit BIG_ENDIAN  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic [31:0] pc,
  input  logic [1:0]  addr_lo,
  input  logic        waitrequest,
  input  logic        branch_cond,
  output logic [2:0]  state,
  output logic        ir_en,
  output logic        pc_en,
  output logic        target_en,
  output logic [1:0]  pc_sel,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_addr_sel,
  output logic [3:0]  byte_en,
  output logic        reg_write,
  output logic [1:0]  reg_src,
  output logic        muldiv_start,
  output logic        hilo_write,
  output logic        halt,
  output logic        addr_error
);

  // Sequencer states (encoding is visible on the state port)
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_EXEC1  = 3'd2;
  localparam logic [2:0] S_EXEC2  = 3'd3;
  localparam logic [2:0] S_MULDIV = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL function codes
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  // REGIMM rt selectors
  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  // The wait counter is preloaded with _CYCLES-2 so that EXEC1 plus the
  // MULDIV cycles add up to exactly _CYCLES cycles of unit occupancy.
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);
  localparam bit MULT_ONE = (MULT_CYCLES == 1);
  localparam bit DIV_ONE  = (DIV_CYCLES == 1);

  logic [2:0]       state_q, state_d;
  logic             delay_pending_q, delay_pending_d;
  logic [1:0]       pc_sel_q, pc_sel_d;
  logic [CNT_W-1:0] counter_q, counter_d;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;

  logic dec_alu, dec_load, dec_store, dec_mult, dec_div, dec_mthilo;
  logic dec_jump, dec_jreg, dec_branch, dec_link;
  logic acc_byte, acc_half, acc_word, acc_any;
  logic misaligned;
  logic [3:0] be_lane;
  logic [3:0] be_bus;
  logic complete;
  logic redirect;
  logic unused_ir_bits;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];
  assign rt     = instruction[20:16];
  // Register fields and immediates are the datapath's business only.
  assign unused_ir_bits = ^{instruction[25:21], instruction[15:6]};

  assign state = state_q;

  // Instruction class decode; anything unrecognised leaves all flags low (NOP)
  always_comb begin
    dec_alu    = 1'b0;
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    dec_mult   = 1'b0;
    dec_div    = 1'b0;
    dec_mthilo = 1'b0;
    dec_jump   = 1'b0;
    dec_jreg   = 1'b0;
    dec_branch = 1'b0;
    dec_link   = 1'b0;
    acc_byte   = 1'b0;
    acc_half   = 1'b0;
    acc_word   = 1'b0;
    acc_any    = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU, F_MFHI, F_MFLO: dec_alu = 1'b1;
          F_JR: begin
            dec_jump = 1'b1;
            dec_jreg = 1'b1;
          end
          F_JALR: begin
            dec_jump = 1'b1;
            dec_jreg = 1'b1;
            dec_link = 1'b1;
          end
          F_MTHI, F_MTLO:  dec_mthilo = 1'b1;
          F_MULT, F_MULTU: dec_mult   = 1'b1;
          F_DIV, F_DIVU:   dec_div    = 1'b1;
          default: ;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: dec_branch = 1'b1;
          RT_BLTZAL, RT_BGEZAL: begin
            dec_branch = 1'b1;
            dec_link   = 1'b1;
          end
          default: ;
        endcase
      end
      OP_J:   dec_jump = 1'b1;
      OP_JAL: begin
        dec_jump = 1'b1;
        dec_link = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: dec_branch = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: dec_alu = 1'b1;
      OP_LB, OP_LBU: begin
        dec_load = 1'b1;
        acc_byte = 1'b1;
      end
      OP_LH, OP_LHU: begin
        dec_load = 1'b1;
        acc_half = 1'b1;
      end
      OP_LW: begin
        dec_load = 1'b1;
        acc_word = 1'b1;
      end
      OP_LWL, OP_LWR: begin
        dec_load = 1'b1;
        acc_any  = 1'b1;
      end
      OP_SB: begin
        dec_store = 1'b1;
        acc_byte  = 1'b1;
      end
      OP_SH: begin
        dec_store = 1'b1;
        acc_half  = 1'b1;
      end
      OP_SW: begin
        dec_store = 1'b1;
        acc_word  = 1'b1;
      end
      default: ;
    endcase
  end

  // Lane enables in little-endian lane order, plus alignment check.
  // LWL/LWR merge partial words in the datapath, so they fetch all lanes.
  always_comb begin
    be_lane    = 4'b0000;
    misaligned = (acc_half && addr_lo[0]) || (acc_word && (addr_lo != 2'b00));
    if (acc_byte) begin
      be_lane = 4'b0001 << addr_lo;
    end else if (acc_half) begin
      be_lane = addr_lo[1] ? 4'b1100 : 4'b0011;
    end else if (acc_word || acc_any) begin
      be_lane = 4'b1111;
    end
  end

  // Big-endian buses see address byte k on lane 3-k
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      if (BIG_ENDIAN) begin : g_big
        assign be_bus[gi] = be_lane[3-gi];
      end else begin : g_little
        assign be_bus[gi] = be_lane[gi];
      end
    end
  endgenerate

  // Next-state and output decode; 'complete' marks the cycle an
  // instruction retires, where the PC advance and delay-slot logic apply.
  always_comb begin
    state_d         = state_q;
    delay_pending_d = delay_pending_q;
    pc_sel_d        = pc_sel_q;
    counter_d       = counter_q;
    ir_en           = 1'b0;
    pc_en           = 1'b0;
    target_en       = 1'b0;
    pc_sel          = 2'b00;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_addr_sel    = 1'b0;
    byte_en         = 4'b0000;
    reg_write       = 1'b0;
    reg_src         = 2'b00;
    muldiv_start    = 1'b0;
    hilo_write      = 1'b0;
    halt            = 1'b0;
    addr_error      = 1'b0;
    complete        = 1'b0;
    redirect        = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        if (pc == 32'd0) begin
          state_d = S_HALT;
        end else begin
          mem_read = 1'b1;
          byte_en  = 4'b1111;
          if (!waitrequest) begin
            ir_en   = 1'b1;
            state_d = S_EXEC1;
          end
        end
      end

      S_EXEC1: begin
        if ((dec_load || dec_store) && misaligned) begin
          addr_error = 1'b1;
          state_d    = S_HALT;
        end else if (dec_load) begin
          mem_read     = 1'b1;
          mem_addr_sel = 1'b1;
          byte_en      = be_bus;
          if (!waitrequest) state_d = S_EXEC2;
        end else if (dec_store) begin
          mem_write    = 1'b1;
          mem_addr_sel = 1'b1;
          byte_en      = be_bus;
          if (!waitrequest) complete = 1'b1;
        end else if (dec_mult || dec_div) begin
          muldiv_start = 1'b1;
          if ((dec_mult && MULT_ONE) || (dec_div && DIV_ONE)) begin
            hilo_write = 1'b1;
            complete   = 1'b1;
          end else begin
            counter_d = dec_mult ? MULT_LOAD : DIV_LOAD;
            state_d   = S_MULDIV;
          end
        end else if (dec_mthilo) begin
          hilo_write = 1'b1;
          complete   = 1'b1;
        end else begin
          complete = 1'b1;
          if (dec_alu) reg_write = 1'b1;
          // Link writes happen whether or not the branch is taken
          if (dec_link) begin
            reg_write = 1'b1;
            reg_src   = 2'b10;
          end
          // A branch sitting in a delay slot cannot start a new redirect
          redirect = !delay_pending_q && (dec_jump || (dec_branch && branch_cond));
        end
      end

      S_EXEC2: begin
        reg_write = 1'b1;
        reg_src   = 2'b01;
        complete  = 1'b1;
      end

      S_MULDIV: begin
        if (counter_q == '0) begin
          hilo_write = 1'b1;
          complete   = 1'b1;
        end else begin
          counter_d = counter_q - 1'b1;
        end
      end

      S_HALT: halt = 1'b1;

      default: state_d = S_HALT;
    endcase

    // Retirement: the delay-slot instruction executes at PC+4, and the
    // instruction after it takes the latched redirect.
    if (complete) begin
      pc_en   = 1'b1;
      state_d = S_FETCH;
      if (redirect) begin
        target_en       = 1'b1;
        delay_pending_d = 1'b1;
        pc_sel_d        = dec_jreg ? 2'b10 : 2'b01;
      end else if (delay_pending_q) begin
        pc_sel          = pc_sel_q;
        delay_pending_d = 1'b0;
      end
    end
  end

  // State, delay-slot and wait-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      delay_pending_q <= 1'b0;
      pc_sel_q        <= 2'b00;
      counter_q       <= '0;
    end else begin
      state_q         <= state_d;
      delay_pending_q <= delay_pending_d;
      pc_sel_q        <= pc_sel_d;
      counter_q       <= counter_d;
    end
  end

endmodule
